md_unit: RTL and testbench

//  Multiply/divide unit with the architectural HI/LO registers. Sits beside the ALU in the execute stage.

---
 rtl/md_unit_pkg.sv | 47 ++++
 rtl/md_div_core.sv | 41 ++++
 rtl/md_unit.sv | 127 ++++++++++++
 tb/tb_md_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// ============================================================================
// Module  : md_unit_pkg
// Brief   : Operation codes, commit modes and helpers for the mult/div unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package md_unit_pkg;

  localparam int MD_OP_LEN = 4;

  localparam logic [MD_OP_LEN-1:0] MD_OP_NONE  = 4'd0;
  localparam logic [MD_OP_LEN-1:0] MD_OP_MULT  = 4'd1;
  localparam logic [MD_OP_LEN-1:0] MD_OP_MULTU = 4'd2;
  localparam logic [MD_OP_LEN-1:0] MD_OP_DIV   = 4'd3;
  localparam logic [MD_OP_LEN-1:0] MD_OP_DIVU  = 4'd4;
  localparam logic [MD_OP_LEN-1:0] MD_OP_MTHI  = 4'd5;
  localparam logic [MD_OP_LEN-1:0] MD_OP_MTLO  = 4'd6;
  // Accumulate codes stay reserved even when the feature is compiled out.
  localparam logic [MD_OP_LEN-1:0] MD_OP_MADD  = 4'd7;
  localparam logic [MD_OP_LEN-1:0] MD_OP_MADDU = 4'd8;
  localparam logic [MD_OP_LEN-1:0] MD_OP_MSUB  = 4'd9;
  localparam logic [MD_OP_LEN-1:0] MD_OP_MSUBU = 4'd10;

  // What the commit edge does with the pending result.
  typedef enum logic [1:0] {
    CM_KEEP = 2'd0,
    CM_LOAD = 2'd1,
    CM_ADD  = 2'd2,
    CM_SUB  = 2'd3
  } commit_mode_e;

  // True for ops that occupy the unit and raise busy.
  function automatic logic md_is_long(input logic [MD_OP_LEN-1:0] op);
    logic r;
    r = (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
        (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
`ifdef MD_MADD_EN
    r = r || (op == MD_OP_MADD) || (op == MD_OP_MADDU) ||
             (op == MD_OP_MSUB) || (op == MD_OP_MSUBU);
`endif
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_div_core.sv
// ============================================================================
// Module  : md_div_core
// Brief   : Combinational 32-bit signed/unsigned divider with sign fix-up.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module md_div_core (
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_div;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;

  assign w_a_neg  = is_signed & a[31];
  assign w_b_neg  = is_signed & b[31];
  // 0x80000000 negates to itself, which is still its correct unsigned magnitude,
  // so the 0x80000000 / -1 overflow case falls out as quot=0x80000000, rem=0.
  assign w_a_mag  = w_a_neg ? (32'd0 - a) : a;
  assign w_b_mag  = w_b_neg ? (32'd0 - b) : b;
  assign div_zero = (b == 32'd0);
  assign w_b_div  = div_zero ? 32'd1 : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_div;
  assign w_r_mag  = w_a_mag % w_b_div;

  assign quot = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign rem  = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

endmodule

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// Module  : md_unit
// Brief   : Multi-cycle multiply/divide unit holding the architectural HI/LO.
//           Define MD_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module md_unit
  import md_unit_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [MD_OP_LEN-1:0] op,
  input  logic [31:0]          a,
  input  logic [31:0]          b,
  output logic                 busy,
  output logic [31:0]          hi,
  output logic [31:0]          lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic               r_busy;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_pend_hi;
  logic [31:0]        r_pend_lo;
  commit_mode_e       r_pend_mode;

  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic [31:0]        w_quot;
  logic [31:0]        w_rem;
  logic               w_div_zero;
  logic               w_long;
  logic [CNT_W-1:0]   w_lat;
  logic [63:0]        w_res;
  commit_mode_e       w_mode;

  assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_prod_u = {32'd0, a} * {32'd0, b};
  assign w_long   = md_is_long(op);

  md_div_core u_div_core (
    .is_signed (op == MD_OP_DIV),
    .a         (a),
    .b         (b),
    .quot      (w_quot),
    .rem       (w_rem),
    .div_zero  (w_div_zero)
  );

  always_comb begin
    w_res  = 64'd0;
    w_mode = CM_KEEP;
    w_lat  = CNT_W'(MUL_LAT);
    case (op)
      MD_OP_MULT:  begin w_res = w_prod_s; w_mode = CM_LOAD; end
      MD_OP_MULTU: begin w_res = w_prod_u; w_mode = CM_LOAD; end
      MD_OP_DIV, MD_OP_DIVU: begin
        w_res  = {w_rem, w_quot};
        // Divide by zero still burns the full latency but leaves HI/LO alone.
        w_mode = w_div_zero ? CM_KEEP : CM_LOAD;
        w_lat  = CNT_W'(DIV_LAT);
      end
`ifdef MD_MADD_EN
      MD_OP_MADD:  begin w_res = w_prod_s; w_mode = CM_ADD; end
      MD_OP_MADDU: begin w_res = w_prod_u; w_mode = CM_ADD; end
      MD_OP_MSUB:  begin w_res = w_prod_s; w_mode = CM_SUB; end
      MD_OP_MSUBU: begin w_res = w_prod_u; w_mode = CM_SUB; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy      <= 1'b0;
      r_cnt       <= '0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_pend_hi   <= 32'd0;
      r_pend_lo   <= 32'd0;
      r_pend_mode <= CM_KEEP;
    end else if (r_busy) begin
      // Anything presented while busy, including MTHI/MTLO, is dropped.
      if (r_cnt == CNT_W'(1)) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
        case (r_pend_mode)
          CM_LOAD: {r_hi, r_lo} <= {r_pend_hi, r_pend_lo};
          CM_ADD:  {r_hi, r_lo} <= {r_hi, r_lo} + {r_pend_hi, r_pend_lo};
          CM_SUB:  {r_hi, r_lo} <= {r_hi, r_lo} - {r_pend_hi, r_pend_lo};
          default: ;
        endcase
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end else if (start) begin
      if (w_long) begin
        r_busy      <= 1'b1;
        r_cnt       <= w_lat;
        r_pend_hi   <= w_res[63:32];
        r_pend_lo   <= w_res[31:0];
        r_pend_mode <= w_mode;
      end else if (op == MD_OP_MTHI) begin
        r_hi <= a;
      end else if (op == MD_OP_MTLO) begin
        r_lo <= a;
      end
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Module  : tb_md_unit
// Brief   : Self-checking bench for md_unit: directed corner cases plus random
//           ops checked against an arithmetic HI/LO model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_md_unit;
  import md_unit_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic [MD_OP_LEN-1:0] op;
  logic [31:0]          a;
  logic [31:0]          b;
  logic                 busy;
  logic [31:0]          hi;
  logic [31:0]          lo;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour: new {hi,lo} from the op, its operands and the current {hi,lo}.
  function automatic logic [63:0] model(input logic [MD_OP_LEN-1:0] o,
                                        input logic [31:0] x, input logic [31:0] y,
                                        input logic [63:0] acc);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      MD_OP_MULT:  return sx * sy;
      MD_OP_MULTU: return ux * uy;
      MD_OP_DIV: begin
        if (y == 32'd0) return acc;
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      MD_OP_DIVU: begin
        if (y == 32'd0) return acc;
        return {32'(ux % uy), 32'(ux / uy)};
      end
      MD_OP_MTHI:  return {x, acc[31:0]};
      MD_OP_MTLO:  return {acc[63:32], x};
`ifdef MD_MADD_EN
      MD_OP_MADD:  return acc + 64'(sx * sy);
      MD_OP_MADDU: return acc + ux * uy;
      MD_OP_MSUB:  return acc - 64'(sx * sy);
      MD_OP_MSUBU: return acc - ux * uy;
`endif
      default:     return acc;
    endcase
  endfunction

  function automatic int exp_lat(input logic [MD_OP_LEN-1:0] o);
    case (o)
      MD_OP_MULT, MD_OP_MULTU: return MUL_LAT;
      MD_OP_DIV, MD_OP_DIVU:   return DIV_LAT;
`ifdef MD_MADD_EN
      MD_OP_MADD, MD_OP_MADDU, MD_OP_MSUB, MD_OP_MSUBU: return MUL_LAT;
`endif
      default:                 return 0;
    endcase
  endfunction

  // All tasks are entered and left at a negedge.
  task automatic issue(input logic [MD_OP_LEN-1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    op    = MD_OP_NONE;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic [MD_OP_LEN-1:0] o,
                     input logic [31:0] x, input logic [31:0] y);
    logic [63:0] e;
    int          lat;
    int          n;
    e   = model(o, x, y, {m_hi, m_lo});
    lat = exp_lat(o);
    issue(o, x, y);
    wait_idle(n);
    check({tag, ".busy_cycles"}, 32'(n), 32'(lat));
    check({tag, ".hi"}, hi, e[63:32]);
    check({tag, ".lo"}, lo, e[31:0]);
    {m_hi, m_lo} = e;
  endtask

  initial begin
    logic [31:0] pool [8];
    logic [31:0] x, y;
    logic [63:0] e;
    int          n;

    pool = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
             32'h7FFF_FFFF, 32'h2, 32'hFFFF_FFFE, 32'h0001_0000};
    reset = 1'b0;
    start = 1'b0;
    op    = MD_OP_NONE;
    a     = 32'd0;
    b     = 32'd0;
    repeat (2) @(negedge clk);
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.hi", hi, 32'd0);
    check("reset.lo", lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Reset during a multiply discards it immediately.
    run("pre_mthi", MD_OP_MTHI, 32'hAAAA_5555, 32'd0);
    run("pre_mtlo", MD_OP_MTLO, 32'h1357_9BDF, 32'd0);
    issue(MD_OP_MULT, 32'd7, 32'd9);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_mid.busy", {31'd0, busy}, 32'd0);
    check("rst_mid.hi", hi, 32'd0);
    check("rst_mid.lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (8) @(negedge clk);
    check("rst_after.busy", {31'd0, busy}, 32'd0);
    check("rst_after.hi", hi, 32'd0);
    check("rst_after.lo", lo, 32'd0);

    run("mult", MD_OP_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult.hi_const", hi, 32'hFFFF_FFFF);
    check("mult.lo_const", lo, 32'hFFFF_FFFA);
    run("multu", MD_OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    check("multu.hi_const", hi, 32'h0000_0002);
    run("div", MD_OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div.lo_const", lo, 32'hFFFF_FFFD);
    check("div.hi_const", hi, 32'hFFFF_FFFF);
    run("divu", MD_OP_DIVU, 32'd7, 32'd2);
    check("divu.lo_const", lo, 32'd3);

    run("mthi", MD_OP_MTHI, 32'h1234, 32'd0);
    run("mtlo", MD_OP_MTLO, 32'h5678, 32'd0);
    run("div0", MD_OP_DIV, 32'd100, 32'd0);
    check("div0.hi_const", hi, 32'h1234);
    check("div0.lo_const", lo, 32'h5678);
    run("divovf", MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divovf.lo_const", lo, 32'h8000_0000);
    check("divovf.hi_const", hi, 32'd0);

    // MTLO presented while busy must be dropped.
    e = model(MD_OP_MULT, 32'd1000, 32'hFFFF_FFFD, {m_hi, m_lo});
    issue(MD_OP_MULT, 32'd1000, 32'hFFFF_FFFD);
    issue(MD_OP_MTLO, 32'hDEAD_BEEF, 32'd0);
    wait_idle(n);
    check("busy_mtlo.busy_cycles", 32'(n), 32'(MUL_LAT - 1));
    check("busy_mtlo.hi", hi, e[63:32]);
    check("busy_mtlo.lo", lo, e[31:0]);
    {m_hi, m_lo} = e;
    run("b2b", MD_OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);

    // Accumulate: only effective when the feature is built in.
    run("madd_hi", MD_OP_MTHI, 32'd0, 32'd0);
    run("madd_lo", MD_OP_MTLO, 32'hFFFF_FFFF, 32'd0);
    run("madd", MD_OP_MADD, 32'd1, 32'd1);
`ifdef MD_MADD_EN
    check("madd.hi_const", hi, 32'd1);
    check("madd.lo_const", lo, 32'd0);
`else
    check("madd.hi_const", hi, 32'd0);
    check("madd.lo_const", lo, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 40; i++) begin
      x = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
      y = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
      run($sformatf("rnd%0d", i), MD_OP_LEN'($urandom_range(0, 10)), x, y);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
